ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 3000, clock-low inhibit time in clk25 cycles (120 us).
REQ-002 Parameter REQ_CYCLES, default 25, time data and clock are both held low before the clock is released.
REQ-003 Parameter START_TIMEOUT, default 375000, maximum wait (15 ms) for the first device falling edge.
REQ-004 Parameter EDGE_TIMEOUT, default 50000, maximum gap (2 ms) between device clock falling edges, and to bus idle.
REQ-005 Parameter FILTER_LEN, default 8, consecutive equal samples needed to change a filtered line.
REQ-006 clk25  in  1  system clock, 25 MHz.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 tx_data  in  8  command byte to send to the keyboard.
REQ-009 tx_valid  in  1  request to send tx_data.
REQ-010 tx_ready  out  1  block idle; a request is accepted when tx_valid and tx_ready are both 1.
REQ-011 tx_done  out  1  one-cycle pulse: frame sent and ACK received.
REQ-012 tx_error  out  1  one-cycle pulse: timeout or NACK.
REQ-013 ps2_clk_i, ps2_data_i  in  1 each  raw PS/2 pin levels.
REQ-014 ps2_clk_oe, ps2_data_oe  out  1 each  1 drives the pin low (open drain); 0 releases it.

Function
REQ-015 Each raw input SHALL pass a 2-flop synchronizer and then a FILTER_LEN glitch filter; a falling edge is a one-cycle pulse on a filtered 1->0 transition.
REQ-016 FSM states SHALL be IDLE, INHIBIT, REQ, SEND, WAIT_IDLE.
REQ-017 IDLE: tx_ready=1, both oe=0; on accept, latch tx_data, compute parity = ~^tx_data (odd parity), clear the bit counter, and enter INHIBIT on the next cycle.
REQ-018 INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, then enter REQ.
REQ-019 REQ: clk_oe=1, data_oe=1 (start bit) for exactly REQ_CYCLES cycles, then enter SEND.
REQ-020 SEND: clk_oe=0; data_oe holds the start bit until the first falling edge.
REQ-021 SEND, falling edges 1..8: drive data bits d0..d7 (LSB first), with data_oe = ~bit.
REQ-022 SEND, falling edge 9: drive parity, with data_oe = ~parity.
REQ-023 SEND, falling edge 10: drive the stop bit (data_oe=0).
REQ-024 SEND, falling edge 11: sample filtered data; 0 = ACK, 1 = NACK. Then enter WAIT_IDLE.
REQ-025 WAIT_IDLE: both oe=0; when filtered clk and data are both 1, return to IDLE and pulse tx_done (ACK) or tx_error (NACK) in the same cycle.
REQ-026 Watchdog: counts from SEND entry; expiry at START_TIMEOUT before the first edge, or EDGE_TIMEOUT after any later edge or in WAIT_IDLE, SHALL release both lines, pulse tx_error, and go IDLE.
REQ-027 tx_valid while tx_ready=0 SHALL be ignored, not queued; tx_data changes after acceptance have no effect.
REQ-028 A device transmission in progress at accept SHALL be overridden (host inhibit has priority); no pending check.
REQ-029 tx_done and tx_error SHALL never assert in the same cycle; tx_ready SHALL return to 1 in the cycle after either pulse.
REQ-030 Counters SHALL be sized for their parameter maximum and SHALL NOT wrap inside a state.

Reset
REQ-031 rst_n=0 SHALL immediately force ps2_clk_oe=0, ps2_data_oe=0, tx_done=0, tx_error=0, FSM=IDLE, and clear all counters and latches.
REQ-032 After deassertion, tx_ready=1 in the first clk25 cycle; filtered lines SHALL reset to 1 (idle bus).
REQ-033 Reset mid-frame SHALL release both lines with no tx_done/tx_error pulse.

Verification
REQ-034 Send 0xED with a device model (~12.5 kHz clock, ACK) -> clk low for 3000 cycles, data low for 25 cycles, then bits 1,0,1,1,0,1,1,1, parity 1, stop 1, and one tx_done.
REQ-035 Send 0x07 -> parity bit 0; send 0x00 -> parity bit 1; both end with tx_done.
REQ-036 Device never clocks -> tx_error exactly 375000 cycles after SEND entry, both oe=0, tx_ready=1.
REQ-037 Device leaves data high at the 11th edge (NACK) -> tx_error after bus idle, no tx_done.
REQ-038 Device stops after 5 edges -> tx_error 50000 cycles after the 5th edge.
REQ-039 Pulse tx_valid=1 with 0x55 during SEND -> ignored, 0xED frame unchanged.
REQ-040 Assert rst_n=0 at bit 4 -> oe=0 asynchronously, no pulses.
REQ-041 Inject 3-cycle glitches on ps2_clk_i -> no bit advance.

Source files
------------

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter with ACK check and watchdog
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 3000,
  parameter int REQ_CYCLES     = 25,
  parameter int START_TIMEOUT  = 375000,
  parameter int EDGE_TIMEOUT   = 50000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk25,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int PH_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int WD_MAX = (START_TIMEOUT > EDGE_TIMEOUT) ? START_TIMEOUT : EDGE_TIMEOUT;
  localparam int WD_W   = $clog2(WD_MAX + 1);
  localparam int FL_W   = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    SEND      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Index 0 is the clock line, index 1 the data line.
  logic [1:0]            r_meta;
  logic [1:0]            r_sync;
  logic [1:0]            r_filt;
  logic [1:0][FL_W-1:0]  r_fcnt;
  logic                  r_clk_filt_d;

  logic [9:0]            r_shift;
  logic                  r_send_oe;
  logic [3:0]            r_edge_cnt;
  logic                  r_nack;
  logic [PH_W-1:0]       r_phase;
  logic [WD_W-1:0]       r_wdog;

  logic                  w_clk_fall;
  logic                  w_accept;
  logic                  w_phase_end;
  logic [WD_W-1:0]       w_wd_limit;
  logic                  w_wd_expired;
  logic                  w_last_edge;
  logic                  w_bus_idle;
  logic                  w_tx_ready;
  logic                  w_tx_done;
  logic                  w_tx_error;
  logic                  w_clk_oe;
  logic                  w_data_oe;

  // Two-flop synchronizer for both raw pins; idles high like the bus.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 2'b11;
      r_sync <= 2'b11;
    end else begin
      r_meta <= {ps2_data_i, ps2_clk_i};
      r_sync <= r_meta;
    end
  end

  // Glitch filter: a line only flips after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_filt       <= 2'b11;
      r_fcnt       <= '0;
      r_clk_filt_d <= 1'b1;
    end else begin
      r_clk_filt_d <= r_filt[0];
      for (int i = 0; i < 2; i++) begin
        if (r_sync[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == FL_W'(FILTER_LEN - 1)) begin
          r_filt[i] <= r_sync[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_clk_fall = r_clk_filt_d & ~r_filt[0];
  assign w_bus_idle = r_filt[0] & r_filt[1];
  assign w_accept   = (r_state == IDLE) & tx_valid;

  assign w_phase_end = ((r_state == INHIBIT) && (r_phase == PH_W'(INHIBIT_CYCLES - 1))) ||
                       ((r_state == REQ)     && (r_phase == PH_W'(REQ_CYCLES - 1)));

  // The first device edge gets the long start allowance; every later gap the short one.
  assign w_wd_limit   = ((r_state == SEND) && (r_edge_cnt == 4'd0)) ? WD_W'(START_TIMEOUT)
                                                                    : WD_W'(EDGE_TIMEOUT);
  assign w_wd_expired = ((r_state == SEND) || (r_state == WAIT_IDLE)) && (r_wdog == w_wd_limit);
  assign w_last_edge  = (r_state == SEND) && w_clk_fall && (r_edge_cnt == 4'd10);

  // State register.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and output decode; pulses are decoded from the leaving transition.
  always_comb begin
    w_state_nxt = r_state;
    w_tx_ready  = 1'b0;
    w_tx_done   = 1'b0;
    w_tx_error  = 1'b0;
    w_clk_oe    = 1'b0;
    w_data_oe   = 1'b0;
    case (r_state)
      IDLE: begin
        w_tx_ready = 1'b1;
        if (tx_valid) begin
          w_state_nxt = INHIBIT;
        end
      end
      INHIBIT: begin
        w_clk_oe = 1'b1;
        if (w_phase_end) begin
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        w_clk_oe  = 1'b1;
        w_data_oe = 1'b1;
        if (w_phase_end) begin
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        w_data_oe = r_send_oe & ~w_wd_expired;
        if (w_wd_expired) begin
          w_tx_error  = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_last_edge) begin
          w_state_nxt = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (w_bus_idle) begin
          w_tx_done   = ~r_nack;
          w_tx_error  = r_nack;
          w_state_nxt = IDLE;
        end else if (w_wd_expired) begin
          w_tx_error  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Inhibit/request phase timer; cleared on every phase boundary so it never wraps.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
    end else if (((r_state == INHIBIT) || (r_state == REQ)) && !w_phase_end) begin
      r_phase <= r_phase + 1'b1;
    end else begin
      r_phase <= '0;
    end
  end

  // Frame shifter: {stop, parity, d7..d0} shifted out LSB first on device falling edges.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_send_oe  <= 1'b0;
      r_edge_cnt <= '0;
      r_nack     <= 1'b0;
    end else if (w_accept) begin
      r_shift    <= {1'b1, ~^tx_data, tx_data};
      r_send_oe  <= 1'b1;
      r_edge_cnt <= '0;
      r_nack     <= 1'b0;
    end else if ((r_state == SEND) && w_clk_fall && !w_wd_expired) begin
      r_edge_cnt <= r_edge_cnt + 1'b1;
      if (r_edge_cnt < 4'd10) begin
        r_send_oe <= ~r_shift[0];
        r_shift   <= {1'b1, r_shift[9:1]};
      end else begin
        r_send_oe <= 1'b0;
        r_nack    <= r_filt[1];
      end
    end
  end

  // Watchdog: zero outside the bus phases, restarts at 1 on each edge, saturates.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
    end else if ((r_state == SEND) || (r_state == WAIT_IDLE)) begin
      if ((r_state == SEND) && w_clk_fall) begin
        r_wdog <= WD_W'(1);
      end else if (r_wdog != WD_W'(WD_MAX)) begin
        r_wdog <= r_wdog + 1'b1;
      end
    end else begin
      r_wdog <= '0;
    end
  end

  assign tx_ready    = w_tx_ready;
  assign tx_done     = w_tx_done;
  assign tx_error    = w_tx_error;
  assign ps2_clk_oe  = w_clk_oe;
  assign ps2_data_oe = w_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed self-checking bench for ps2_host_tx
module tb_ps2_host_tx;

  localparam int INH = 40;
  localparam int RQ  = 10;
  localparam int STO = 1500;
  localparam int ETO = 400;
  localparam int FL  = 8;
  localparam int HP  = 40;

  logic       clk25 = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_error;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       glitch_low = 1'b0;
  logic       ps2_clk_i;
  logic       ps2_data_i;

  assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low | glitch_low);
  assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

  int n_cmp  = 0;
  int n_fail = 0;
  int n_done = 0;
  int n_err  = 0;
  int n_both = 0;
  int cyc    = 0;
  int err_cyc = 0;
  int fall_cyc = 0;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .REQ_CYCLES(RQ),
    .START_TIMEOUT(STO),
    .EDGE_TIMEOUT(ETO),
    .FILTER_LEN(FL)
  ) dut (
    .clk25(clk25),
    .rst_n(rst_n),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_done(tx_done),
    .tx_error(tx_error),
    .ps2_clk_i(ps2_clk_i),
    .ps2_data_i(ps2_data_i),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #20 clk25 = ~clk25;

  always @(posedge clk25) cyc <= cyc + 1;

  always @(negedge clk25) begin
    if (tx_done) n_done++;
    if (tx_error) begin
      n_err++;
      err_cyc = cyc;
    end
    if (tx_done && tx_error) n_both++;
  end

  // Request a byte, measure the inhibit/request phases, then act as the keyboard clocking it in.
  task automatic run_frame(input logic [7:0] d, input bit ack, input int nedges,
                           input bit glitch, input bit inject,
                           output logic [9:0] bits, output int inh_cnt, output int req_cnt,
                           output logic start_bit, output bit entered);
    bits = '0;
    inh_cnt = 0;
    req_cnt = 0;
    start_bit = 1'b1;
    entered = 1'b0;
    @(posedge clk25);
    #1 tx_data = d;
    tx_valid = 1'b1;
    @(posedge clk25);
    #1 tx_valid = 1'b0;
    tx_data = ~d;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk25);
      if (ps2_clk_oe && !ps2_data_oe) inh_cnt++;
      else if (ps2_clk_oe && ps2_data_oe) req_cnt++;
      else begin
        entered = 1'b1;
        break;
      end
    end
    start_bit = ps2_data_i;
    if (!entered) return;
    for (int e = 1; e <= nedges; e++) begin
      if (e == 11 && ack) dev_data_low = 1'b1;
      repeat (HP / 2) @(posedge clk25);
      #1;
      if (glitch) begin
        glitch_low = 1'b1;
        repeat (3) @(posedge clk25);
        #1 glitch_low = 1'b0;
      end
      if (inject && e == 3) begin
        tx_valid = 1'b1;
        tx_data = 8'h55;
        @(posedge clk25);
        #1 tx_valid = 1'b0;
      end
      repeat (HP / 2) @(posedge clk25);
      #1 dev_clk_low = 1'b1;
      fall_cyc = cyc;
      repeat (HP) @(posedge clk25);
      #1;
      if (e <= 10) bits[e-1] = ps2_data_i;
      dev_clk_low = 1'b0;
    end
    dev_data_low = 1'b0;
  endtask

  // Wait (bounded) for a done/error pulse; returns on the negedge where it is seen.
  task automatic wait_pulse(input int bound, output bit got);
    got = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk25);
      if (tx_done || tx_error) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk25);
    n_cmp++; if (ps2_clk_oe !== 1'b0) begin n_fail++; $display("FAIL rst_clk_oe got=%b exp=0", ps2_clk_oe); end
    n_cmp++; if (ps2_data_oe !== 1'b0) begin n_fail++; $display("FAIL rst_data_oe got=%b exp=0", ps2_data_oe); end
    n_cmp++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL rst_done got=%b exp=0", tx_done); end
    n_cmp++; if (tx_error !== 1'b0) begin n_fail++; $display("FAIL rst_error got=%b exp=0", tx_error); end
    @(posedge clk25);
    #1 rst_n = 1'b1;
    @(negedge clk25);
    n_cmp++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got=%b exp=1", tx_ready); end
    repeat (20) @(negedge clk25);
  endtask

  task automatic test_frame_ed();
    logic [9:0] bits; int inh; int rq; logic sb; bit ent; bit got;
    int d0 = n_done; int e0 = n_err;
    run_frame(8'hED, 1'b1, 11, 1'b0, 1'b0, bits, inh, rq, sb, ent);
    wait_pulse(3000, got);
    n_cmp++; if (got !== 1'b1) begin n_fail++; $display("FAIL ed_pulse_seen got=%b exp=1", got); end
    @(negedge clk25);
    n_cmp++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL ed_ready_after got=%b exp=1", tx_ready); end
    n_cmp++; if (inh !== INH) begin n_fail++; $display("FAIL ed_inhibit_cycles got=%0d exp=%0d", inh, INH); end
    n_cmp++; if (rq !== RQ) begin n_fail++; $display("FAIL ed_req_cycles got=%0d exp=%0d", rq, RQ); end
    n_cmp++; if (sb !== 1'b0) begin n_fail++; $display("FAIL ed_start_bit got=%b exp=0", sb); end
    n_cmp++; if (bits !== 10'h3ED) begin n_fail++; $display("FAIL ed_bits got=%h exp=3ed", bits); end
    n_cmp++; if (n_done - d0 !== 1) begin n_fail++; $display("FAIL ed_done_count got=%0d exp=1", n_done - d0); end
    n_cmp++; if (n_err - e0 !== 0) begin n_fail++; $display("FAIL ed_error_count got=%0d exp=0", n_err - e0); end
  endtask

  task automatic test_parity();
    logic [7:0] dv [2] = '{8'h07, 8'h00};
    logic [9:0] ev [2] = '{10'h207, 10'h300};
    logic       pv [2] = '{1'b0, 1'b1};
    for (int k = 0; k < 2; k++) begin
      logic [9:0] bits; int inh; int rq; logic sb; bit ent; bit got;
      int d0 = n_done; int e0 = n_err;
      run_frame(dv[k], 1'b1, 11, 1'b0, 1'b0, bits, inh, rq, sb, ent);
      wait_pulse(3000, got);
      @(negedge clk25);
      n_cmp++; if (bits[8] !== pv[k]) begin n_fail++; $display("FAIL par_bit_%0d got=%b exp=%b", k, bits[8], pv[k]); end
      n_cmp++; if (bits !== ev[k]) begin n_fail++; $display("FAIL par_bits_%0d got=%h exp=%h", k, bits, ev[k]); end
      n_cmp++; if ((n_done - d0) !== 1 || (n_err - e0) !== 0) begin
        n_fail++; $display("FAIL par_result_%0d got done=%0d err=%0d exp done=1 err=0", k, n_done - d0, n_err - e0);
      end
    end
  endtask

  task automatic test_start_timeout();
    int n = 0; bit ent = 1'b0; bit seen_inh = 1'b0;
    int d0 = n_done; int e0 = n_err;
    @(posedge clk25);
    #1 tx_data = 8'h3C;
    tx_valid = 1'b1;
    @(posedge clk25);
    #1 tx_valid = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk25);
      if (ps2_clk_oe) seen_inh = 1'b1;
      else if (seen_inh) begin ent = 1'b1; break; end
    end
    n_cmp++; if (ent !== 1'b1) begin n_fail++; $display("FAIL sto_send_entry got=%b exp=1", ent); end
    while (!tx_error && n < STO + 100) begin
      @(negedge clk25);
      n++;
    end
    n_cmp++; if (n !== STO) begin n_fail++; $display("FAIL sto_latency got=%0d exp=%0d", n, STO); end
    @(negedge clk25);
    n_cmp++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      n_fail++; $display("FAIL sto_release got clk_oe=%b data_oe=%b exp 0 0", ps2_clk_oe, ps2_data_oe);
    end
    n_cmp++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL sto_ready got=%b exp=1", tx_ready); end
    n_cmp++; if ((n_err - e0) !== 1 || (n_done - d0) !== 0) begin
      n_fail++; $display("FAIL sto_result got done=%0d err=%0d exp done=0 err=1", n_done - d0, n_err - e0);
    end
  endtask

  task automatic test_nack();
    logic [9:0] bits; int inh; int rq; logic sb; bit ent; bit got;
    int d0 = n_done; int e0 = n_err;
    run_frame(8'hA3, 1'b0, 11, 1'b0, 1'b0, bits, inh, rq, sb, ent);
    wait_pulse(3000, got);
    @(negedge clk25);
    n_cmp++; if (bits !== 10'h3A3) begin n_fail++; $display("FAIL nack_bits got=%h exp=3a3", bits); end
    n_cmp++; if ((n_err - e0) !== 1 || (n_done - d0) !== 0) begin
      n_fail++; $display("FAIL nack_result got done=%0d err=%0d exp done=0 err=1", n_done - d0, n_err - e0);
    end
  endtask

  task automatic test_edge_timeout();
    logic [9:0] bits; int inh; int rq; logic sb; bit ent; bit got; int dt;
    int d0 = n_done; int e0 = n_err;
    run_frame(8'h5A, 1'b1, 5, 1'b0, 1'b0, bits, inh, rq, sb, ent);
    wait_pulse(ETO + 200, got);
    @(negedge clk25);
    dt = err_cyc - fall_cyc;
    n_cmp++; if (got !== 1'b1) begin n_fail++; $display("FAIL eto_pulse_seen got=%b exp=1", got); end
    n_cmp++; if (dt < ETO || dt > ETO + FL + 4) begin
      n_fail++; $display("FAIL eto_latency got=%0d exp=%0d..%0d", dt, ETO, ETO + FL + 4);
    end
    n_cmp++; if ((n_err - e0) !== 1 || (n_done - d0) !== 0) begin
      n_fail++; $display("FAIL eto_result got done=%0d err=%0d exp done=0 err=1", n_done - d0, n_err - e0);
    end
  endtask

  task automatic test_ignore_valid();
    logic [9:0] bits; int inh; int rq; logic sb; bit ent; bit got;
    int d0 = n_done; int e0 = n_err;
    run_frame(8'hED, 1'b1, 11, 1'b0, 1'b1, bits, inh, rq, sb, ent);
    wait_pulse(3000, got);
    @(negedge clk25);
    n_cmp++; if (bits !== 10'h3ED) begin n_fail++; $display("FAIL ign_bits got=%h exp=3ed", bits); end
    n_cmp++; if ((n_done - d0) !== 1 || (n_err - e0) !== 0) begin
      n_fail++; $display("FAIL ign_result got done=%0d err=%0d exp done=1 err=0", n_done - d0, n_err - e0);
    end
    repeat (INH + RQ + 10) @(negedge clk25);
    n_cmp++; if (ps2_clk_oe !== 1'b0 || tx_ready !== 1'b1) begin
      n_fail++; $display("FAIL ign_no_queue got clk_oe=%b ready=%b exp 0 1", ps2_clk_oe, tx_ready);
    end
  endtask

  task automatic test_glitch();
    logic [9:0] bits; int inh; int rq; logic sb; bit ent; bit got;
    int d0 = n_done; int e0 = n_err;
    run_frame(8'hED, 1'b1, 11, 1'b1, 1'b0, bits, inh, rq, sb, ent);
    wait_pulse(3000, got);
    @(negedge clk25);
    n_cmp++; if (bits !== 10'h3ED) begin n_fail++; $display("FAIL glitch_bits got=%h exp=3ed", bits); end
    n_cmp++; if ((n_done - d0) !== 1 || (n_err - e0) !== 0) begin
      n_fail++; $display("FAIL glitch_result got done=%0d err=%0d exp done=1 err=0", n_done - d0, n_err - e0);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] bits; int inh; int rq; logic sb; bit ent;
    int d0 = n_done; int e0 = n_err;
    run_frame(8'h00, 1'b1, 4, 1'b0, 1'b0, bits, inh, rq, sb, ent);
    @(negedge clk25);
    n_cmp++; if (ps2_data_oe !== 1'b1) begin n_fail++; $display("FAIL rmid_driving got=%b exp=1", ps2_data_oe); end
    #5 rst_n = 1'b0;
    #1;
    n_cmp++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      n_fail++; $display("FAIL rmid_async_release got clk_oe=%b data_oe=%b exp 0 0", ps2_clk_oe, ps2_data_oe);
    end
    repeat (5) @(posedge clk25);
    #1 rst_n = 1'b1;
    @(negedge clk25);
    n_cmp++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready got=%b exp=1", tx_ready); end
    repeat (200) @(negedge clk25);
    n_cmp++; if ((n_done - d0) !== 0 || (n_err - e0) !== 0) begin
      n_fail++; $display("FAIL rmid_no_pulse got done=%0d err=%0d exp 0 0", n_done - d0, n_err - e0);
    end
  endtask

  initial begin
    test_reset();
    test_frame_ed();
    test_parity();
    test_start_timeout();
    test_nack();
    test_edge_timeout();
    test_ignore_valid();
    test_glitch();
    test_reset_mid();
    n_cmp++; if (n_both !== 0) begin n_fail++; $display("FAIL done_and_error_same_cycle got=%0d exp=0", n_both); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
